// File: rtl/cond_pkg.sv
// Shared types for the condition-flags unit: the NZCV flag record,
// the 4-bit condition-code encoding and the request FSM states.
package cond_pkg;

  localparam int FLAGS_W = 4;

  // Field order matches the external {N,Z,C,V} flag bus.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_LO = 4'h2,
    COND_HS = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator. C is a borrow flag, so the
// unsigned "lower" tests use C=1 and "higher or same" uses C=0.
module cond_eval
  import cond_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   taken
);

  logic n_eq_v;

  assign n_eq_v = (flags.n == flags.v);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_LO: taken = flags.c;
      COND_HS: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = !flags.c && !flags.z;
      COND_LS: taken = flags.c || flags.z;
      COND_GE: taken = n_eq_v;
      COND_LT: taken = !n_eq_v;
      COND_GT: taken = !flags.z && n_eq_v;
      COND_LE: taken = flags.z || !n_eq_v;
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// Architectural NZCV flags register with a one-deep condition-evaluation
// request/response handshake and a saturating signed-overflow counter.
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             zero_in,
  input  logic             negative_in,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] ovf_count
);

  flags_t             flags_in;
  flags_t             eval_flags;
  logic [3:0]         flags_d;
  logic [CNT_W-1:0]   ovf_count_q;
  logic [CNT_W-1:0]   ovf_count_d;
  state_e             state_q;
  state_e             state_d;
  logic               rsp_taken_q;
  logic               rsp_taken_d;
  logic               cond_taken;

  assign flags_in = '{n: negative_in, z: zero_in, c: carry_in, v: overflow_in};

  // With forwarding, a request accepted alongside a flag write sees the new flags.
  assign eval_flags = (FWD_EN && flag_we) ? flags_in : flags_t'(flags_q);

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (cond_e'(req_cond)),
    .taken (cond_taken)
  );

  always_comb begin
    flags_d     = flags_q;
    ovf_count_d = ovf_count_q;
    if (flag_we) begin
      flags_d = flags_in;
      if (overflow_in && (ovf_count_q != {CNT_W{1'b1}})) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_taken_d = rsp_taken_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          rsp_taken_d = cond_taken;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q     <= '0;
      ovf_count_q <= '0;
      state_q     <= ST_IDLE;
      rsp_taken_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      ovf_count_q <= ovf_count_d;
      state_q     <= state_d;
      rsp_taken_q <= rsp_taken_d;
    end
  end

  assign rsp_taken = rsp_taken_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: one instance with forwarding and
// one without, driven in lockstep and checked against an operand-level model.
module tb_cond_flags_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic       zero_in;
  logic       negative_in;
  logic       carry_in;
  logic       overflow_in;
  logic       req_valid;
  logic [3:0] req_cond;
  logic       rsp_ready;

  logic       req_ready_f, rsp_valid_f, rsp_taken_f;
  logic [3:0] flags_q_f, ovf_count_f;
  logic       req_ready_n, rsp_valid_n, rsp_taken_n;
  logic [3:0] flags_q_n, ovf_count_n;

  int checks;
  int failures;

  // Model state: the operands of the last flag write and the overflow tally.
  int cur_a;
  int cur_b;
  int model_ovf;
  bit held_f;
  bit held_n;

  cond_flags_unit #(.CNT_W(4), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .zero_in(zero_in),
    .negative_in(negative_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .req_valid(req_valid), .req_ready(req_ready_f), .req_cond(req_cond),
    .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken_f),
    .flags_q(flags_q_f), .ovf_count(ovf_count_f)
  );

  cond_flags_unit #(.CNT_W(4), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .zero_in(zero_in),
    .negative_in(negative_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .req_valid(req_valid), .req_ready(req_ready_n), .req_cond(req_cond),
    .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken_n),
    .flags_q(flags_q_n), .ovf_count(ovf_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sval(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Flags a 4-bit subtractor would produce for a - b, packed {N,Z,C,V}.
  function automatic logic [3:0] alu_flags(input int a, input int b);
    int res;
    int sd;
    res = (a - b) & 15;
    sd  = sval(a) - sval(b);
    return {res >= 8, res == 0, a < b, (sd > 7) || (sd < -8)};
  endfunction

  // Condition outcome expressed as the comparison it stands for on a and b.
  function automatic bit ref_taken(input int a, input int b, input int cond);
    int  res;
    int  sd;
    bit  ovf;
    res = (a - b) & 15;
    sd  = sval(a) - sval(b);
    ovf = (sd > 7) || (sd < -8);
    case (cond)
      0:  return a == b;
      1:  return a != b;
      2:  return a < b;
      3:  return a >= b;
      4:  return res >= 8;
      5:  return res < 8;
      6:  return ovf;
      7:  return !ovf;
      8:  return a > b;
      9:  return a <= b;
      10: return sval(a) >= sval(b);
      11: return sval(a) < sval(b);
      12: return sval(a) > sval(b);
      13: return sval(a) <= sval(b);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input int a, input int b,
                               input bit rv, input int cond, input bit rr);
    logic [3:0] f;
    f = alu_flags(a, b);
    flag_we     = we;
    negative_in = f[3];
    zero_in     = f[2];
    carry_in    = f[1];
    overflow_in = f[0];
    req_valid   = rv;
    req_cond    = 4'(cond);
    rsp_ready   = rr;
  endtask

  task automatic modelWrite(input int a, input int b);
    logic [3:0] f;
    cur_a = a;
    cur_b = b;
    f = alu_flags(a, b);
    if (f[0] && model_ovf < 15) model_ovf++;
    checkOutput("flags_q_fwd", flags_q_f, f);
    checkOutput("flags_q_nofwd", flags_q_n, f);
    checkOutput("ovf_count_fwd", ovf_count_f, model_ovf);
    checkOutput("ovf_count_nofwd", ovf_count_n, model_ovf);
  endtask

  task automatic write_flags(input int a, input int b);
    @(negedge clk);
    applyStimulus(1'b1, a, b, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    modelWrite(a, b);
  endtask

  task automatic accept(input int cond, input bit we, input int a, input int b, input int dir);
    @(negedge clk);
    checkOutput("req_ready_idle_fwd", req_ready_f, 1);
    checkOutput("req_ready_idle_nofwd", req_ready_n, 1);
    applyStimulus(we, a, b, 1'b1, cond, 1'b0);
    @(posedge clk);
    #1;
    held_n = ref_taken(cur_a, cur_b, cond);
    held_f = we ? ref_taken(a, b, cond) : held_n;
    if (we) modelWrite(a, b);
    if (dir >= 0) checkOutput($sformatf("directed_cond%0d", cond), rsp_taken_f, dir);
    checkOutput("rsp_valid_fwd", rsp_valid_f, 1);
    checkOutput("rsp_valid_nofwd", rsp_valid_n, 1);
    checkOutput("rsp_taken_fwd", rsp_taken_f, held_f);
    checkOutput("rsp_taken_nofwd", rsp_taken_n, held_n);
    checkOutput("req_ready_resp_fwd", req_ready_f, 0);
    checkOutput("req_ready_resp_nofwd", req_ready_n, 0);
  endtask

  task automatic hold(input bit we, input int a, input int b);
    @(negedge clk);
    applyStimulus(we, a, b, 1'b1, $urandom_range(0, 15), 1'b0);
    @(posedge clk);
    #1;
    if (we) modelWrite(a, b);
    checkOutput("hold_rsp_valid_fwd", rsp_valid_f, 1);
    checkOutput("hold_rsp_valid_nofwd", rsp_valid_n, 1);
    checkOutput("hold_taken_fwd", rsp_taken_f, held_f);
    checkOutput("hold_taken_nofwd", rsp_taken_n, held_n);
    checkOutput("hold_req_ready_fwd", req_ready_f, 0);
    checkOutput("hold_req_ready_nofwd", req_ready_n, 0);
  endtask

  task automatic release_rsp();
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("release_rsp_valid_fwd", rsp_valid_f, 0);
    checkOutput("release_rsp_valid_nofwd", rsp_valid_n, 0);
    checkOutput("release_req_ready_fwd", req_ready_f, 1);
    checkOutput("release_req_ready_nofwd", req_ready_n, 1);
    checkOutput("release_taken_fwd", rsp_taken_f, held_f);
    checkOutput("release_taken_nofwd", rsp_taken_n, held_n);
  endtask

  initial begin
    int a;
    int b;
    int mode;
    checks    = 0;
    failures  = 0;
    model_ovf = 0;
    cur_a     = 0;
    cur_b     = 0;

    // Reset
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", req_ready_f, 0);
    checkOutput("reset_rsp_valid", rsp_valid_f, 0);
    checkOutput("reset_rsp_taken", rsp_taken_f, 0);
    checkOutput("reset_flags_q", flags_q_f, 0);
    checkOutput("reset_ovf_count", ovf_count_f, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 - 5
    write_flags(3, 5);
    accept(2, 1'b0, 0, 0, 1);  release_rsp();
    accept(11, 1'b0, 0, 0, 1); release_rsp();
    accept(10, 1'b0, 0, 0, 0); release_rsp();
    accept(3, 1'b0, 0, 0, 0);  release_rsp();

    // 5 - 5
    write_flags(5, 5);
    accept(0, 1'b0, 0, 0, 1);  release_rsp();
    accept(3, 1'b0, 0, 0, 1);  release_rsp();
    accept(8, 1'b0, 0, 0, 0);  release_rsp();
    accept(9, 1'b0, 0, 0, 1);  release_rsp();
    accept(12, 1'b0, 0, 0, 0); release_rsp();

    // -8 - 1 overflows
    write_flags(8, 1);
    checkOutput("ovf_first", ovf_count_f, 1);
    accept(11, 1'b0, 0, 0, 1); release_rsp();
    accept(6, 1'b0, 0, 0, 1);  release_rsp();

    // Backpressure, including a flag write while the response is held
    accept(14, 1'b0, 0, 0, 1);
    hold(1'b0, 0, 0);
    hold(1'b1, 3, 5);
    hold(1'b0, 0, 0);
    release_rsp();
    write_flags(3, 5);
    accept(0, 1'b0, 0, 0, 0);
    hold(1'b1, 5, 5);
    hold(1'b0, 0, 0);
    release_rsp();

    // Forwarding: Z goes 0 -> 1 in the accept cycle
    write_flags(3, 5);
    accept(0, 1'b1, 5, 5, -1);
    checkOutput("fwd_eq_fwden1", rsp_taken_f, 1);
    checkOutput("fwd_eq_fwden0", rsp_taken_n, 0);
    release_rsp();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a    = $urandom_range(0, 15);
      b    = $urandom_range(0, 15);
      mode = $urandom_range(0, 2);
      if (mode == 0) write_flags(a, b);
      accept($urandom_range(0, 15), mode == 1, a, b, -1);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        hold($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 15));
      end
      release_rsp();
    end

    // Saturation
    for (int i = 0; i < 17; i++) write_flags(8, 1);
    checkOutput("ovf_saturated_fwd", ovf_count_f, 15);
    checkOutput("ovf_saturated_nofwd", ovf_count_n, 15);

    // Reset while a response is pending
    accept(14, 1'b0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midreset_rsp_valid", rsp_valid_f, 0);
    checkOutput("midreset_flags_q", flags_q_f, 0);
    checkOutput("midreset_ovf_count", ovf_count_f, 0);
    checkOutput("midreset_rsp_taken", rsp_taken_f, 0);
    checkOutput("midreset_req_ready", req_ready_f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_req_ready", req_ready_f, 1);
    checkOutput("post_reset_rsp_valid", rsp_valid_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
